alu_cmd_issue: RTL and testbench



---
 rtl/alu_cmd_issue.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_issue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// Command-issue and result-capture stage around a 4-bit combinational ALU.
// Commands queue in a small FIFO; the head drives the ALU and its result is captured into a valid/ready slot.
module alu_cmd_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [2:0]               in_opcode,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_opcode,
    input  logic [3:0]               alu_result,
    input  logic                     alu_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_result,
    output logic                     out_zero,
    output logic [2:0]               out_opcode,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    // entry layout: {opcode[10:8], a[7:4], b[3:0]}
    logic [10:0]      mem_q [DEPTH];
    logic [10:0]      head;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_result_q, out_result_d;
    logic             out_zero_q, out_zero_d;
    logic [2:0]       out_opcode_q, out_opcode_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic empty;
    logic push;
    logic cap;
    logic consume;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q < FULL_C);
    assign push     = in_valid & in_ready;
    assign cap      = !empty & (!out_valid_q | out_ready);
    assign consume  = out_valid_q & out_ready;
    assign head     = mem_q[rd_ptr_q];

    // Zeros while empty so the ALU never sees stale or uninitialised storage.
    always_comb begin
        alu_a      = 4'd0;
        alu_b      = 4'd0;
        alu_opcode = 3'd0;
        if (!empty) begin
            alu_opcode = head[10:8];
            alu_a      = head[7:4];
            alu_b      = head[3:0];
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_opcode_d = out_opcode_q;
        op_count_d   = op_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (cap) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, cap})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (cap) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_zero_d   = alu_zero;
            out_opcode_d = head[10:8];
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        if (consume) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= 4'd0;
            out_zero_q   <= 1'b0;
            out_opcode_q <= 3'd0;
            op_count_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_opcode_q <= out_opcode_d;
            op_count_q   <= op_count_d;
        end
    end

    // Storage is not reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_opcode, in_a, in_b};
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_opcode = out_opcode_q;
    assign fifo_count = count_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: queue-based reference model plus directed literal checks.
module tb_alu_cmd_issue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b;
    logic [2:0] in_opcode;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_zero;
    logic [2:0] out_opcode;
    logic [2:0] fifo_count;
    logic [CNT_W-1:0] op_count;

    alu_cmd_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_opcode(out_opcode),
        .fifo_count(fifo_count), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in combinational ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A<<1, 7 A>>1.
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return {a[2:0], 1'b0};
            default: return {1'b0, a[3:1]};
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(alu_a, alu_b, alu_opcode);
        alu_zero   = (alu_result == 4'd0);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", n, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted commands, one output slot, wrapping counter.
    typedef struct { logic [3:0] a; logic [3:0] b; logic [2:0] op; } cmd_t;
    cmd_t        mq[$];
    bit          mv;
    logic [3:0]  mres;
    bit          mz;
    logic [2:0]  mop;
    int          mcnt;
    cmd_t        mh;
    bit          m_push, m_cap, m_cons;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mv = 0; mres = 0; mz = 0; mop = 0; mcnt = 0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_cap  = (mq.size() != 0) && (!mv || out_ready);
            m_cons = mv && out_ready;
            if (m_cons) mcnt = (mcnt + 1) % (1 << CNT_W);
            if (m_cap) begin
                mh   = mq.pop_front();
                mres = alu_f(mh.a, mh.b, mh.op);
                mz   = (mres == 4'd0);
                mop  = mh.op;
                mv   = 1;
            end else if (m_cons) begin
                mv = 0;
            end
            if (m_push) mq.push_back('{a: in_a, b: in_b, op: in_opcode});
        end
    end

    logic [2:0] dut_seq[$];
    bit         win = 0;
    int         ov_cnt;
    int         max_fc;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("out_valid", int'(out_valid), int'(mv));
            chk("op_count", int'(op_count), mcnt);
            if (mq.size() != 0) begin
                chk("alu_a", int'(alu_a), int'(mq[0].a));
                chk("alu_b", int'(alu_b), int'(mq[0].b));
                chk("alu_opcode", int'(alu_opcode), int'(mq[0].op));
            end else begin
                chk("alu_a_empty", int'(alu_a), 0);
                chk("alu_b_empty", int'(alu_b), 0);
                chk("alu_opcode_empty", int'(alu_opcode), 0);
            end
            if (mv) begin
                chk("out_result", int'(out_result), int'(mres));
                chk("out_zero", int'(out_zero), int'(mz));
                chk("out_opcode", int'(out_opcode), int'(mop));
            end
            if (win) begin
                if (out_valid) ov_cnt++;
                if (int'(fifo_count) > max_fc) max_fc = int'(fifo_count);
            end
            if (out_valid && out_ready) dut_seq.push_back(out_opcode);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        in_valid = v; in_a = a; in_b = b; in_opcode = op;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
    endtask

    logic [3:0] held;

    initial begin
        rst_n = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        #12 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // Mid-stream async reset: 1 in slot, 3 queued.
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 1), 4'(i), 3'(i));
            step();
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        chk("pre_rst_fifo_count", int'(fifo_count), 3);
        chk("pre_rst_out_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_fifo_count", int'(fifo_count), 0);
        chk("async_op_count", int'(op_count), 0);
        chk("async_in_ready", int'(in_ready), 1);
        chk("async_alu_a", int'(alu_a), 0);
        chk("async_alu_b", int'(alu_b), 0);
        chk("async_alu_opcode", int'(alu_opcode), 0);
        #3 rst_n = 1'b1;

        // Single ADD: 0101 + 0011 = 1000, captured one edge after acceptance.
        out_ready = 1'b1;
        step();
        drive(1'b1, 4'b0101, 4'b0011, 3'b000);
        step();
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        chk("add_not_yet_valid", int'(out_valid), 0);
        step();
        chk("add_out_valid", int'(out_valid), 1);
        chk("add_out_result", int'(out_result), 8);
        chk("add_out_zero", int'(out_zero), 0);
        chk("add_out_opcode", int'(out_opcode), 0);
        step();

        // SUB to zero: 0101 - 0101.
        drive(1'b1, 4'b0101, 4'b0101, 3'b001);
        step();
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        step();
        chk("sub_out_valid", int'(out_valid), 1);
        chk("sub_out_result", int'(out_result), 0);
        chk("sub_out_zero", int'(out_zero), 1);
        chk("sub_out_opcode", int'(out_opcode), 1);
        step();

        // Backpressure: 5 pushes with out_ready low -> 1 in slot, FIFO full.
        out_ready = 1'b0;
        drive(1'b1, 4'd3, 4'd4, 3'd0);   step();
        drive(1'b1, 4'd9, 4'd2, 3'd1);   step();
        drive(1'b1, 4'd12, 4'd10, 3'd2); step();
        drive(1'b1, 4'd12, 4'd3, 3'd3);  step();
        drive(1'b1, 4'd6, 4'd5, 3'd4);   step();
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        chk("full_fifo_count", int'(fifo_count), 4);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);
        chk("full_out_result", int'(out_result), 7);
        held = out_result;
        // One rejected attempt while full, then idle stall.
        drive(1'b1, 4'd1, 4'd1, 3'd5);
        step();
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_result", int'(out_result), int'(held));
            step();
        end
        chk("stall_fifo_count", int'(fifo_count), 4);
        dut_seq.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("drain_count", dut_seq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_seq.size()) chk("drain_order", int'(dut_seq[i]), i);
        end
        step();
        chk("drain_empty_valid", int'(out_valid), 0);

        // Streaming after a fresh reset: 8 back-to-back commands, opcodes 0..7.
        do_reset();
        step();
        ov_cnt = 0; max_fc = 0; win = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i * 3), 4'(i + 1), 3'(i));
            step();
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        for (int i = 0; i < 3; i++) step();
        win = 0;
        chk("stream_valid_cycles", ov_cnt, 8);
        chk("stream_max_fifo", int'(max_fc <= 1), 1);
        chk("stream_op_count", int'(op_count), 8);

        // Counter wrap: 248 more operations -> 256 total.
        for (int i = 0; i < 248; i++) begin
            drive(1'b1, 4'(i), 4'(~i), 3'(i % 8));
            step();
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0);
        for (int i = 0; i < 3; i++) step();
        chk("wrap_op_count", int'(op_count), 0);
        chk("wrap_fifo_count", int'(fifo_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached actual=running required=finished");
        $fatal(1);
    end

endmodule
